// File: rtl/i2c_reg_target_if.sv
// I2C pad-side bus bundle for i2c_reg_target.
//   scl_in  raw SCL pad level (into the target)
//   sda_in  raw SDA pad level (into the target)
//   sda_oe  1 = target pulls SDA low, 0 = released
// master modport: the external controller / pad model.
// slave modport:  the register target.
interface i2c_reg_target_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_reg_target.sv
// I2C target exposing NUM_REGS 8-bit read/write registers.
// Register pointer auto-increments with wrap. Supports repeated START.
// Out-of-range pointer bytes are NACKed. Each register write emits a one-cycle strobe.
//
// Ports
//   clock        system clock (>= 16x SCL)
//   reset        synchronous, active-high
//   bus          scl_in / sda_in pad levels in, sda_oe open-drain pull-down out
//   regs_packed  register k at bits [8k+7:8k]
//   wr_strobe    one-cycle pulse per register write
//   wr_idx       index written, valid with wr_strobe
//   busy         high from an address-matched START until STOP
//
// state      | meaning
// -----------+-----------------------------------------------------
// IDLE       | bus ignored until START
// ADDR       | shifting device address + R/W bit
// ADDR_ACK   | driving ACK for matched address
// PTR        | shifting register pointer byte
// PTR_ACK    | driving ACK for in-range pointer
// WDATA      | shifting write data byte
// WDATA_ACK  | driving ACK for written byte
// RDATA      | driving read byte MSB first
// RDATA_ACK  | SDA released, sampling controller ACK/NACK
module i2c_reg_target #(
    parameter logic [6:0] DEV_ADDR   = 7'h42,
    parameter int         NUM_REGS   = 9,
    parameter int         FILTER_LEN = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    i2c_reg_target_if.slave       bus,
    output logic [8*NUM_REGS-1:0] regs_packed,
    output logic                  wr_strobe,
    output logic [6:0]            wr_idx,
    output logic                  busy
);

    localparam int              PTR_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REGS - 1);
    localparam logic [8:0]      NUM_REGS_9  = 9'(NUM_REGS);
    localparam logic [2:0]      FILT_RELOAD = 3'(FILTER_LEN);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } state_t;

    // ---------------------------------------------------------------
    // Input path: index 0 = SCL, index 1 = SDA
    // ---------------------------------------------------------------
    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] filt;
    logic [1:0] filt_d;
    logic [2:0] fcnt [2];

    assign raw = {bus.sda_in, bus.scl_in};

    // Each filter count is a down-counter: it reloads whenever the synchronised
    // sample matches the filtered level. The level flips when the count reaches
    // terminal count on a still-differing sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            filt    <= 2'b11;
            filt_d  <= 2'b11;
            fcnt[0] <= FILT_RELOAD;
            fcnt[1] <= FILT_RELOAD;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= FILT_RELOAD;
                end else if (fcnt[i] == 3'd1) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= FILT_RELOAD;
                end else begin
                    fcnt[i] <= fcnt[i] - 3'd1;
                end
            end
        end
    end

    logic scl_f;
    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_f     = filt[0];
    assign sda_f     = filt[1];
    assign scl_rise  = scl_f & ~filt_d[0];
    assign scl_fall  = ~scl_f & filt_d[0];
    // SCL must be high in both cycles so an SDA change near an SCL edge is not misread.
    assign start_det = scl_f & filt_d[0] & filt_d[1] & ~sda_f;
    assign stop_det  = scl_f & filt_d[0] & ~filt_d[1] & sda_f;

    // ---------------------------------------------------------------
    // FSM and datapath registers
    // ---------------------------------------------------------------
    state_t           state, state_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shreg, shreg_n;
    logic [PTR_W-1:0] ptr, ptr_n;
    logic             sda_oe_q, sda_oe_n;
    logic             busy_q, busy_n;
    logic             mack_q, mack_n;
    logic             wr_strobe_q, wr_strobe_n;
    logic [6:0]       wr_idx_q, wr_idx_n;
    logic             reg_we;
    logic [7:0]       wr_data;
    logic [7:0]       rd_byte;
    logic [PTR_W-1:0] next_ptr;
    logic [7:0]       regs_q [NUM_REGS];

    assign wr_data  = {shreg[6:0], sda_f};
    assign rd_byte  = regs_q[ptr];
    assign next_ptr = (ptr == LAST_IDX) ? '0 : ptr + PTR_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            ptr         <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            mack_q      <= 1'b1;
            wr_strobe_q <= 1'b0;
            wr_idx_q    <= '0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            ptr         <= ptr_n;
            sda_oe_q    <= sda_oe_n;
            busy_q      <= busy_n;
            mack_q      <= mack_n;
            wr_strobe_q <= wr_strobe_n;
            wr_idx_q    <= wr_idx_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        ptr_n       = ptr;
        sda_oe_n    = sda_oe_q;
        busy_n      = busy_q;
        mack_n      = mack_q;
        wr_strobe_n = 1'b0;
        wr_idx_n    = wr_idx_q;
        reg_we      = 1'b0;

        case (state)
            IDLE: begin
                sda_oe_n = 1'b0;
            end
            ADDR: begin
                if (scl_rise) begin
                    shreg_n   = wr_data;
                    bit_cnt_n = bit_cnt + 4'd1;
                end else if (scl_fall && bit_cnt == 4'd8) begin
                    if (shreg[7:1] == DEV_ADDR) begin
                        state_n  = ADDR_ACK;
                        sda_oe_n = 1'b1;
                        busy_n   = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            ADDR_ACK: begin
                // shreg[0] still holds the R/W bit here.
                if (scl_fall) begin
                    bit_cnt_n = '0;
                    if (shreg[0]) begin
                        state_n  = RDATA;
                        shreg_n  = rd_byte;
                        sda_oe_n = ~rd_byte[7];
                    end else begin
                        state_n  = PTR;
                        sda_oe_n = 1'b0;
                    end
                end
            end
            PTR: begin
                if (scl_rise) begin
                    shreg_n   = wr_data;
                    bit_cnt_n = bit_cnt + 4'd1;
                end else if (scl_fall && bit_cnt == 4'd8) begin
                    if ({1'b0, shreg} < NUM_REGS_9) begin
                        ptr_n    = shreg[PTR_W-1:0];
                        state_n  = PTR_ACK;
                        sda_oe_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            PTR_ACK, WDATA_ACK: begin
                if (scl_fall) begin
                    state_n   = WDATA;
                    bit_cnt_n = '0;
                    sda_oe_n  = 1'b0;
                end
            end
            WDATA: begin
                if (scl_rise) begin
                    shreg_n   = wr_data;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        reg_we      = 1'b1;
                        wr_strobe_n = 1'b1;
                        wr_idx_n    = 7'(ptr);
                        ptr_n       = next_ptr;
                    end
                end else if (scl_fall && bit_cnt == 4'd8) begin
                    state_n  = WDATA_ACK;
                    sda_oe_n = 1'b1;
                end
            end
            RDATA: begin
                if (scl_rise) begin
                    bit_cnt_n = bit_cnt + 4'd1;
                end else if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        state_n  = RDATA_ACK;
                        sda_oe_n = 1'b0;
                        ptr_n    = next_ptr;
                    end else if (bit_cnt != 4'd0) begin
                        shreg_n  = {shreg[6:0], 1'b0};
                        sda_oe_n = ~shreg[6];
                    end
                end
            end
            RDATA_ACK: begin
                if (scl_rise) begin
                    mack_n = sda_f;
                end else if (scl_fall) begin
                    bit_cnt_n = '0;
                    if (!mack_q) begin
                        state_n  = RDATA;
                        shreg_n  = rd_byte;
                        sda_oe_n = ~rd_byte[7];
                    end else begin
                        state_n  = IDLE;
                        sda_oe_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n  = IDLE;
                sda_oe_n = 1'b0;
            end
        endcase

        // Bus conditions override the state walk. A register commit raised above
        // in the same cycle still lands, because reg_we is not cleared here.
        if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Register file with per-entry address decode
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_REGS; k++) begin
            if (reset) begin
                regs_q[k] <= '0;
            end else if (reg_we && (ptr == PTR_W'(k))) begin
                regs_q[k] <= wr_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign regs_packed[8*g +: 8] = regs_q[g];
    end

    assign bus.sda_oe = sda_oe_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_idx     = wr_idx_q;
    assign busy       = busy_q;

endmodule
